// File: rtl/pdm_capture_ctrl_pkg.sv
// pdm_capture_ctrl_pkg: shared state encoding and counter-width helper for the PDM capture sequencer
package pdm_capture_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pdm_capture_ctrl_clk_div.sv
// pdm_capture_ctrl_clk_div: M_CLK divider with in-period sample points
//  clk, rst        : system clock, async active-high reset
//  active          : registered state is not IDLE (counter runs)
//  active_d        : next state is not IDLE (M_CLK may be high next cycle)
//  m_clk           : registered 50% duty bit clock, high for div_cnt in [0, CLK_DIV/2-1]
//  rise_pt/fall_pt : div_cnt at the high-/low-phase sample offset (fall_pt only with STEREO_EN)
//  last            : final cycle of the M_CLK period
module pdm_capture_ctrl_clk_div
  import pdm_capture_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 40,
  parameter int SAMPLE_OFS = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic active_d,
  output logic m_clk,
  output logic rise_pt,
  output logic fall_pt,
  output logic last
);
  localparam int DW = cw(CLK_DIV);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic m_clk_q, m_clk_d;
  // M_CLK is computed from the next count so the register lines up with div_cnt
  always_comb begin
    div_cnt_d = (!active || div_cnt_q == DW'(CLK_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
    m_clk_d   = active_d && (div_cnt_d < DW'(CLK_DIV / 2));
    rise_pt   = div_cnt_q == DW'(SAMPLE_OFS);
    last      = div_cnt_q == DW'(CLK_DIV - 1);
`ifdef STEREO_EN
    fall_pt   = div_cnt_q == DW'(CLK_DIV / 2 + SAMPLE_OFS);
`else
    fall_pt   = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      m_clk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      m_clk_q   <= m_clk_d;
    end
  end
  assign m_clk = m_clk_q;
endmodule

// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl: PDM mic power-up sequencer, M_CLK/strobe generation and CIC valid gating
//  clk, rst      : system clock, async active-high reset
//  en            : capture request level
//  M_CLK         : PDM bit clock to microphone
//  m_clk_rising  : high-phase sample strobe; m_clk_falling : low-phase strobe (STEREO_EN, else 0)
//  cic_valid     : CIC output valid from pdm_mic; out_valid : cic_valid passed only in RUN
//  state, busy   : sequencer state (0 IDLE..3 RUN) and state != IDLE
//  sample_cnt    : out_valid pulses since last WARMUP entry
//  Optional macro: STEREO_EN enables the low-phase strobe.
module pdm_capture_ctrl
  import pdm_capture_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 40,
  parameter int SAMPLE_OFS = 19,
  parameter int WARMUP_CYC = 25000,
  parameter int DISCARD    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        M_CLK,
  output logic        m_clk_rising,
  output logic        m_clk_falling,
  input  logic        cic_valid,
  output logic        out_valid,
  output logic [1:0]  state,
  output logic        busy,
  output logic [31:0] sample_cnt
);
  localparam int WW  = cw(WARMUP_CYC + 1);
  localparam int DCW = cw(DISCARD + 1);
  if ((CLK_DIV % 2) != 0 || CLK_DIV < 8 || SAMPLE_OFS < 0 || SAMPLE_OFS >= CLK_DIV / 2 ||
      WARMUP_CYC < 1 || DISCARD < 0) begin : g_bad_params
    $error("pdm_capture_ctrl: illegal parameter set");
  end
  state_e         state_q, state_d;
  logic [WW-1:0]  warm_cnt_q, warm_cnt_d;
  logic [DCW-1:0] disc_cnt_q, disc_cnt_d;
  logic [31:0]    sample_cnt_q, sample_cnt_d;
  logic           stop_pend_q, stop_pend_d;
  logic           rise_pt, fall_pt, last, sample_ok;
  pdm_capture_ctrl_clk_div #(
    .CLK_DIV    (CLK_DIV),
    .SAMPLE_OFS (SAMPLE_OFS)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .active   (state_q != ST_IDLE),
    .active_d (state_d != ST_IDLE),
    .m_clk    (M_CLK),
    .rise_pt  (rise_pt),
    .fall_pt  (fall_pt),
    .last     (last)
  );
  // Gating uses the registered state and stop flag; a pending stop silences strobes at once
  always_comb begin
    sample_ok     = (state_q == ST_SETTLE || state_q == ST_RUN) && !stop_pend_q;
    m_clk_rising  = rise_pt && sample_ok;
    m_clk_falling = fall_pt && sample_ok;
    out_valid     = cic_valid && state_q == ST_RUN && !stop_pend_q;
    state_d       = state_q;
    warm_cnt_d    = warm_cnt_q;
    disc_cnt_d    = disc_cnt_q;
    sample_cnt_d  = sample_cnt_q + {31'd0, out_valid};
    stop_pend_d   = stop_pend_q || (state_q != ST_IDLE && !en);
    if (state_q == ST_IDLE) begin
      stop_pend_d = 1'b0;
      if (en) begin
        state_d      = ST_WARMUP;
        warm_cnt_d   = '0;
        disc_cnt_d   = '0;
        sample_cnt_d = '0;
      end
    end else if (stop_pend_q && last) begin
      state_d     = ST_IDLE;
      stop_pend_d = 1'b0;
    end else if (state_q == ST_WARMUP && last) begin
      warm_cnt_d = warm_cnt_q + 1'b1;
      if (32'(warm_cnt_q) == 32'(WARMUP_CYC - 1)) state_d = (DISCARD == 0) ? ST_RUN : ST_SETTLE;
    end else if (state_q == ST_SETTLE && cic_valid) begin
      disc_cnt_d = disc_cnt_q + 1'b1;
      if (32'(disc_cnt_q) == 32'(DISCARD - 1)) state_d = ST_RUN;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      warm_cnt_q   <= '0;
      disc_cnt_q   <= '0;
      sample_cnt_q <= '0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      disc_cnt_q   <= disc_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      stop_pend_q  <= stop_pend_d;
    end
  end
  assign state      = state_q;
  assign busy       = state_q != ST_IDLE;
  assign sample_cnt = sample_cnt_q;
endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// tb_pdm_capture_ctrl: directed table-driven bench for pdm_capture_ctrl (CLK_DIV=8, SAMPLE_OFS=3, WARMUP_CYC=4, DISCARD=2)
module tb_pdm_capture_ctrl;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, cic_valid = 1'b0;
  logic M_CLK, m_clk_rising, m_clk_falling, out_valid, busy;
  logic [1:0] state;
  logic [31:0] sample_cnt;
  int checks = 0, failures = 0;
`ifdef STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif
  pdm_capture_ctrl #(
    .CLK_DIV    (8),
    .SAMPLE_OFS (3),
    .WARMUP_CYC (4),
    .DISCARD    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .M_CLK         (M_CLK),
    .m_clk_rising  (m_clk_rising),
    .m_clk_falling (m_clk_falling),
    .cic_valid     (cic_valid),
    .out_valid     (out_valid),
    .state         (state),
    .busy          (busy),
    .sample_cnt    (sample_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        en, cic, mclk, rise, fall, ov;
    logic [1:0]  st;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl [18];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, ".M_CLK"}, 32'(M_CLK), 32'(v.mclk));
    chk({tag, ".rising"}, 32'(m_clk_rising), 32'(v.rise));
    chk({tag, ".falling"}, 32'(m_clk_falling), 32'(v.fall & STEREO));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.ov));
    chk({tag, ".state"}, 32'(state), 32'(v.st));
    chk({tag, ".busy"}, 32'(busy), 32'(v.st != 2'd0));
    chk({tag, ".sample_cnt"}, sample_cnt, v.cnt);
  endtask
  task automatic go_run();
    int n = 0;
    while (state != 2'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_settle", 32'(state), 2);
    repeat (2) begin
      @(negedge clk);
      cic_valid = 1'b1;
      @(negedge clk);
      cic_valid = 1'b0;
    end
    #1;
    chk("reach_run", 32'(state), 3);
    chk("run_cnt_zero", sample_cnt, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    vec_t rv;
    // cycles 33..50: settle, run, stop with en re-asserted while the stop is pending
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 32'd1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'd2};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 32'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'd3};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'd3};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'd3};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'd3};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'd3};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'd3};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd3};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0};
    repeat (2) @(negedge clk);
    cic_valid = 1'b1;
    #1;
    chk_vec("reset", '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    cic_valid = 1'b0;
    #1;
    chk_vec("idle_en", '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0});
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      #1;
      rv = '{1'b1, 1'b0, ((c - 1) % 8) < 4, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0};
      chk_vec($sformatf("warm%0d", c), rv);
    end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      en = tbl[i].en;
      cic_valid = tbl[i].cic;
      #1;
      chk_vec($sformatf("vec%0d", i), tbl[i]);
    end
    go_run();
    @(negedge clk);
    cic_valid = 1'b1;
    #1;
    chk("pre_rst_out_valid", 32'(out_valid), 1);
    n = 0;
    while (M_CLK !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("pre_rst_mclk", 32'(M_CLK), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mclk", 32'(M_CLK), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_cnt", sample_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    cic_valid = 1'b0;
    go_run();
    @(negedge clk);
    dut.sample_cnt_q = 32'hFFFF_FFFF;
    cic_valid = 1'b1;
    #1;
    chk("wrap_pre", sample_cnt, 32'hFFFF_FFFF);
    chk("wrap_ov", 32'(out_valid), 1);
    @(negedge clk);
    cic_valid = 1'b0;
    #1;
    chk("wrap_cnt", sample_cnt, 0);
    chk("wrap_state", 32'(state), 3);
    @(negedge clk);
    cic_valid = 1'b1;
    @(negedge clk);
    cic_valid = 1'b0;
    #1;
    chk("wrap_cnt_next", sample_cnt, 1);
    n = 0;
    while (m_clk_rising !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rise_found", 32'(m_clk_rising), 1);
    for (int k = 0; k < 2; k++) begin
      chk("rise_mclk_hi", 32'(M_CLK), 1);
      @(negedge clk);
      #1;
      chk("mclk_low_after_rise", 32'(M_CLK), 0);
      repeat (3) @(negedge clk);
      #1;
      chk("falling_strobe", 32'(m_clk_falling), 32'(STEREO));
      repeat (4) @(negedge clk);
      #1;
      chk("rise_period8", 32'(m_clk_rising), 1);
    end
    en = 1'b0;
    n = 0;
    while (state != 2'd0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("final_idle", 32'(state), 0);
    chk("final_mclk", 32'(M_CLK), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
